// File: rtl/instr_mem_loader_pkg.sv
// ----------------------------------------------------------------------------
// instr_mem_loader_pkg
// Shared definitions for the instruction memory write path (loader) and the
// instruction fetch path.
//   - INSTR_DEPTH / INSTR_IDX_W / INSTR_XLEN : instruction memory geometry
//   - loader_state_e                          : loader FSM encoding
//   - instr_addr_valid()                      : byte-address legality check
//                                               shared with fetch (PC check)
// ----------------------------------------------------------------------------
package instr_mem_loader_pkg;

    localparam int INSTR_DEPTH = 1024;
    localparam int INSTR_IDX_W = 10;
    localparam int INSTR_XLEN  = 64;

    typedef enum logic [1:0] {
        LDR_IDLE = 2'd0,
        LDR_LOAD = 2'd1,
        LDR_DONE = 2'd2
    } loader_state_e;

    // Word-aligned and word index <= INSTR_DEPTH-1. INSTR_DEPTH is a power of
    // two, so the index bound reduces to "all bits above the index are zero".
    function automatic logic instr_addr_valid(input logic [INSTR_XLEN-1:0] addr);
        return (addr[1:0] == 2'b00) &&
               (addr[INSTR_XLEN-1:INSTR_IDX_W+2] == '0);
    endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// ----------------------------------------------------------------------------
// instr_mem_loader
// Fills the instruction memory from a valid/ready word stream (boot/debug
// UART). Holds the core while loading and rejects illegal target ranges.
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   start, base_addr,   load request (sampled in IDLE only), first byte
//   word_count          address, number of words (1..DEPTH)
//   abort               cancel an in-progress load
//   s_valid, s_data,    input word stream
//   s_ready
//   mem_we, mem_waddr,  instr_mem write port (registered, 1-cycle latency)
//   mem_wdata
//   cpu_hold            fetch stall while not IDLE
//   done                one-cycle pulse on successful completion
//   err                 sticky error (bad request or abort)
//   words_written       words accepted in the current / last load
// ----------------------------------------------------------------------------
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10,
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [XLEN-1:0]  base_addr,
    input  logic [CNT_W-1:0] word_count,
    input  logic             abort,
    input  logic             s_valid,
    input  logic [31:0]      s_data,
    output logic             s_ready,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_waddr,
    output logic [31:0]      mem_wdata,
    output logic             cpu_hold,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_written
);

    localparam logic [1:0] IDLE = LDR_IDLE;
    localparam logic [1:0] LOAD = LDR_LOAD;
    localparam logic [1:0] DONE = LDR_DONE;

    // End-of-range sum is kept two bits wider than the index so that a large
    // base plus a large count cannot wrap and slip past the bound check.
    localparam int               SUM_W     = IDX_W + 2;
    localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(DEPTH);

    logic [1:0]       state_reg, state_next;
    logic [IDX_W-1:0] wr_idx_reg, wr_idx_next;
    logic [CNT_W-1:0] remaining_reg, remaining_next;
    logic [CNT_W-1:0] words_written_reg, words_written_next;
    logic             err_reg, err_next;
    logic             mem_we_reg, mem_we_next;
    logic [IDX_W-1:0] mem_waddr_reg, mem_waddr_next;
    logic [31:0]      mem_wdata_reg, mem_wdata_next;

    logic [IDX_W-1:0] base_idx;
    logic [SUM_W-1:0] end_sum;
    logic             start_ok;
    logic             handshake;

    assign base_idx  = base_addr[IDX_W+1:2];
    assign end_sum   = {2'b00, base_idx} + {{(SUM_W-CNT_W){1'b0}}, word_count};
    assign start_ok  = instr_addr_valid(INSTR_XLEN'(base_addr)) &&
                       (word_count != '0) && (end_sum <= DEPTH_SUM);

    // abort gates ready so no word is consumed in the cycle it is raised.
    assign s_ready   = (state_reg == LOAD) && !abort;
    assign handshake = s_valid && s_ready;

    always_comb begin
        state_next         = state_reg;
        wr_idx_next        = wr_idx_reg;
        remaining_next     = remaining_reg;
        words_written_next = words_written_reg;
        err_next           = err_reg;
        mem_we_next        = 1'b0;
        mem_waddr_next     = mem_waddr_reg;
        mem_wdata_next     = mem_wdata_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        err_next           = 1'b0;
                        words_written_next = '0;
                        wr_idx_next        = base_idx;
                        remaining_next     = word_count;
                        state_next         = LOAD;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (handshake) begin
                    mem_we_next        = 1'b1;
                    mem_waddr_next     = wr_idx_reg;
                    mem_wdata_next     = s_data;
                    wr_idx_next        = wr_idx_reg + 1'b1;
                    words_written_next = words_written_reg + 1'b1;
                    remaining_next     = remaining_reg - 1'b1;
                    if (remaining_reg == CNT_W'(1))
                        state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            wr_idx_reg        <= '0;
            remaining_reg     <= '0;
            words_written_reg <= '0;
            err_reg           <= 1'b0;
            mem_we_reg        <= 1'b0;
            mem_waddr_reg     <= '0;
            mem_wdata_reg     <= '0;
        end else begin
            state_reg         <= state_next;
            wr_idx_reg        <= wr_idx_next;
            remaining_reg     <= remaining_next;
            words_written_reg <= words_written_next;
            err_reg           <= err_next;
            mem_we_reg        <= mem_we_next;
            mem_waddr_reg     <= mem_waddr_next;
            mem_wdata_reg     <= mem_wdata_next;
        end
    end

    assign mem_we        = mem_we_reg;
    assign mem_waddr     = mem_waddr_reg;
    assign mem_wdata     = mem_wdata_reg;
    assign cpu_hold      = (state_reg != IDLE);
    assign done          = (state_reg == DONE);
    assign err           = err_reg;
    assign words_written = words_written_reg;

endmodule

// File: tb/tb_instr_mem_loader.sv
// ----------------------------------------------------------------------------
// tb_instr_mem_loader
// Table-driven directed vectors for the basic load and request validation,
// plus hand-written sequences for gapped streams, abort, start-while-busy and
// reset in the middle of a load. A negedge monitor logs every memory write.
// ----------------------------------------------------------------------------
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] base_addr;
    logic [10:0] word_count;
    logic        abort;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        mem_we;
    logic [9:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [10:0] words_written;

    always #5 clk = ~clk;

    instr_mem_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .word_count    (word_count),
        .abort         (abort),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .mem_we        (mem_we),
        .mem_waddr     (mem_waddr),
        .mem_wdata     (mem_wdata),
        .cpu_hold      (cpu_hold),
        .done          (done),
        .err           (err),
        .words_written (words_written)
    );

    typedef struct {
        logic        start;
        logic [63:0] base;
        logic [10:0] cnt;
        logic        valid;
        logic [31:0] data;
        logic        exp_we;
        logic [9:0]  exp_waddr;
        logic [31:0] exp_wdata;
        logic        exp_done;
        logic        exp_hold;
        logic        exp_ready;
        logic [10:0] exp_ww;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Write / done log captured away from the active edge.
    logic [9:0]  log_idx[$];
    logic [31:0] log_dat[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            log_idx.push_back(mem_waddr);
            log_dat.push_back(mem_wdata);
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic st, input logic [63:0] b, input logic [10:0] c,
                       input logic v, input logic [31:0] d,
                       input logic we, input logic [9:0] wa, input logic [31:0] wd,
                       input logic dn, input logic hd, input logic rd,
                       input logic [10:0] ww, input logic er);
        vec_t x;
        x.start = st; x.base = b; x.cnt = c; x.valid = v; x.data = d;
        x.exp_we = we; x.exp_waddr = wa; x.exp_wdata = wd; x.exp_done = dn;
        x.exp_hold = hd; x.exp_ready = rd; x.exp_ww = ww; x.exp_err = er;
        vecs.push_back(x);
    endtask

    // Each row: drive inputs, check outputs before the next edge, then clock.
    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            start      = vecs[i].start;
            base_addr  = vecs[i].base;
            word_count = vecs[i].cnt;
            s_valid    = vecs[i].valid;
            s_data     = vecs[i].data;
            abort      = 1'b0;
            #1;
            $display("row %0d: start=%0b base=0x%0h cnt=%0d valid=%0b | we=%0b idx=%0d data=0x%0h done=%0b hold=%0b ready=%0b ww=%0d err=%0b",
                     i, start, base_addr, word_count, s_valid, mem_we, mem_waddr,
                     mem_wdata, done, cpu_hold, s_ready, words_written, err);
            chk($sformatf("row%0d_we", i), 64'(mem_we), 64'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                chk($sformatf("row%0d_waddr", i), 64'(mem_waddr), 64'(vecs[i].exp_waddr));
                chk($sformatf("row%0d_wdata", i), 64'(mem_wdata), 64'(vecs[i].exp_wdata));
            end
            chk($sformatf("row%0d_done", i),  64'(done),          64'(vecs[i].exp_done));
            chk($sformatf("row%0d_hold", i),  64'(cpu_hold),      64'(vecs[i].exp_hold));
            chk($sformatf("row%0d_ready", i), 64'(s_ready),       64'(vecs[i].exp_ready));
            chk($sformatf("row%0d_ww", i),    64'(words_written), 64'(vecs[i].exp_ww));
            chk($sformatf("row%0d_err", i),   64'(err),           64'(vecs[i].exp_err));
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lb, db;

        // Basic load (rows 0..6)
        //   st  base      cnt v  data          we idx  wdata         dn hd rd ww er
        add(1, 64'h0,    4, 0, 32'h0,        0, 0,   32'h0,        0, 0, 0, 0, 0);
        add(0, 64'h0,    0, 1, 32'h00000013, 0, 0,   32'h0,        0, 1, 1, 0, 0);
        add(0, 64'h0,    0, 1, 32'h00100093, 1, 0,   32'h00000013, 0, 1, 1, 1, 0);
        add(0, 64'h0,    0, 1, 32'h00200113, 1, 1,   32'h00100093, 0, 1, 1, 2, 0);
        add(0, 64'h0,    0, 1, 32'h00300193, 1, 2,   32'h00200113, 0, 1, 1, 3, 0);
        add(0, 64'h0,    0, 0, 32'h0,        1, 3,   32'h00300193, 1, 1, 0, 4, 0);
        add(0, 64'h0,    0, 0, 32'h0,        0, 0,   32'h0,        0, 0, 0, 4, 0);
        // Invalid requests, then a valid one clears err (rows 7..14)
        add(1, 64'h6,    1, 0, 32'h0,        0, 0,   32'h0,        0, 0, 0, 4, 0);
        add(1, 64'h1000, 1, 0, 32'h0,        0, 0,   32'h0,        0, 0, 0, 4, 1);
        add(1, 64'hFFC,  2, 0, 32'h0,        0, 0,   32'h0,        0, 0, 0, 4, 1);
        add(1, 64'h0,    0, 0, 32'h0,        0, 0,   32'h0,        0, 0, 0, 4, 1);
        add(1, 64'h10,   1, 0, 32'h0,        0, 0,   32'h0,        0, 0, 0, 4, 1);
        add(0, 64'h0,    0, 1, 32'hDEADBEEF, 0, 0,   32'h0,        0, 1, 1, 0, 0);
        add(0, 64'h0,    0, 0, 32'h0,        1, 4,   32'hDEADBEEF, 1, 1, 0, 1, 0);
        add(0, 64'h0,    0, 0, 32'h0,        0, 0,   32'h0,        0, 0, 0, 1, 0);

        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        abort = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_we",    64'(mem_we),        64'(0));
        chk("reset_hold",  64'(cpu_hold),      64'(0));
        chk("reset_done",  64'(done),          64'(0));
        chk("reset_err",   64'(err),           64'(0));
        chk("reset_ww",    64'(words_written), 64'(0));
        chk("reset_ready", 64'(s_ready),       64'(0));
        rst_n = 1'b1;

        run_rows(0, 14);

        // Gapped stream at the top of memory
        lb = log_idx.size(); db = done_cnt;
        start = 1'b1; base_addr = 64'hFF8; word_count = 2;
        step();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            s_valid = (k == 1 || k == 4);
            s_data  = 32'hC0 + 32'(k);
            step();
        end
        s_valid = 1'b0;
        $display("gapped: writes=%0d done=%0d ww=%0d err=%0b", log_idx.size() - lb, done_cnt - db, words_written, err);
        chk("gap_nwrites", 64'(log_idx.size() - lb), 64'(2));
        chk("gap_idx0",  64'(log_idx[lb]),     64'(1022));
        chk("gap_dat0",  64'(log_dat[lb]),     64'h000000C1);
        chk("gap_idx1",  64'(log_idx[lb + 1]), 64'(1023));
        chk("gap_dat1",  64'(log_dat[lb + 1]), 64'h000000C4);
        chk("gap_done",  64'(done_cnt - db),   64'(1));
        chk("gap_hold",  64'(cpu_hold),        64'(0));
        chk("gap_ww",    64'(words_written),   64'(2));

        // Abort after three handshakes
        lb = log_idx.size(); db = done_cnt;
        start = 1'b1; base_addr = 64'h100; word_count = 8;
        step();
        start = 1'b0; s_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_data = 32'hA0 + 32'(k);
            step();
        end
        abort = 1'b1; s_data = 32'hA3;
        #1;
        chk("abort_ready", 64'(s_ready),  64'(0));
        chk("abort_hold",  64'(cpu_hold), 64'(1));
        chk("abort_lastwe", 64'(mem_we),  64'(1));
        chk("abort_lastidx", 64'(mem_waddr), 64'(66));
        step();
        abort = 1'b0; s_valid = 1'b0;
        #1;
        chk("abort_idle_hold", 64'(cpu_hold),      64'(0));
        chk("abort_err",       64'(err),           64'(1));
        chk("abort_ww",        64'(words_written), 64'(3));
        chk("abort_we_after",  64'(mem_we),        64'(0));
        step();
        $display("abort: writes=%0d done=%0d ww=%0d err=%0b", log_idx.size() - lb, done_cnt - db, words_written, err);
        chk("abort_nwrites", 64'(log_idx.size() - lb), 64'(3));
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("abort_idx%0d", k), 64'(log_idx[lb + k]), 64'(64 + k));
            chk($sformatf("abort_dat%0d", k), 64'(log_dat[lb + k]), 64'(32'hA0 + 32'(k)));
        end
        chk("abort_done", 64'(done_cnt - db), 64'(0));

        // Start during LOAD is ignored
        lb = log_idx.size(); db = done_cnt;
        start = 1'b1; base_addr = 64'h40; word_count = 3;
        step();
        base_addr = 64'h80; word_count = 1; s_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_data = 32'hB0 + 32'(k);
            step();
        end
        start = 1'b0; s_valid = 1'b0;
        #1;
        chk("busy_done",  64'(done),      64'(1));
        chk("busy_lastidx", 64'(mem_waddr), 64'(18));
        step();
        step();
        $display("busy-start: writes=%0d done=%0d ww=%0d err=%0b", log_idx.size() - lb, done_cnt - db, words_written, err);
        chk("busy_nwrites", 64'(log_idx.size() - lb), 64'(3));
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("busy_idx%0d", k), 64'(log_idx[lb + k]), 64'(16 + k));
            chk($sformatf("busy_dat%0d", k), 64'(log_dat[lb + k]), 64'(32'hB0 + 32'(k)));
        end
        chk("busy_donecnt", 64'(done_cnt - db), 64'(1));
        chk("busy_ww",      64'(words_written), 64'(3));
        chk("busy_hold",    64'(cpu_hold),      64'(0));
        chk("busy_err",     64'(err),           64'(0));

        // Reset in the middle of a load
        start = 1'b1; base_addr = 64'h0; word_count = 4;
        step();
        start = 1'b0; s_valid = 1'b1;
        s_data = 32'h11; step();
        s_data = 32'h22; step();
        rst_n = 1'b0; start = 1'b1;
        #1;
        $display("reset mid-load: we=%0b hold=%0b ww=%0d err=%0b", mem_we, cpu_hold, words_written, err);
        chk("rst_we",    64'(mem_we),        64'(0));
        chk("rst_waddr", 64'(mem_waddr),     64'(0));
        chk("rst_wdata", 64'(mem_wdata),     64'(0));
        chk("rst_hold",  64'(cpu_hold),      64'(0));
        chk("rst_ready", 64'(s_ready),       64'(0));
        chk("rst_ww",    64'(words_written), 64'(0));
        step();
        chk("rst_hold_edge", 64'(cpu_hold), 64'(0));
        chk("rst_we_edge",   64'(mem_we),   64'(0));
        rst_n = 1'b1; start = 1'b0; s_valid = 1'b0;
        run_rows(0, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
